// File: rtl/uart_rx_peripheral_top_if.sv
// Receive-side bundle of the UART RX peripheral: the serial line in, plus the
// byte stream out to the core with its valid/ready handshake and status pulses.
interface uart_rx_peripheral_top_if;
    logic       i_uart_rx_sdata;
    logic       i_uart_rx_ready;
    logic [7:0] o_uart_rx_pdata;
    logic       o_uart_rx_valid;
    logic       o_uart_fifo_full;
    logic       o_uart_par_err;
    logic       o_uart_stop_err;
    logic       o_uart_overrun;

    modport slave (
        input  i_uart_rx_sdata,
        input  i_uart_rx_ready,
        output o_uart_rx_pdata,
        output o_uart_rx_valid,
        output o_uart_fifo_full,
        output o_uart_par_err,
        output o_uart_stop_err,
        output o_uart_overrun
    );

    modport master (
        output i_uart_rx_sdata,
        output i_uart_rx_ready,
        input  o_uart_rx_pdata,
        input  o_uart_rx_valid,
        input  o_uart_fifo_full,
        input  o_uart_par_err,
        input  o_uart_stop_err,
        input  o_uart_overrun
    );
endinterface

// File: rtl/uart_rx_peripheral_top.sv
// UART receiver: 16x oversampled framing with majority voting, parity/stop checks,
// and a first-word-fall-through byte FIFO drained through a valid/ready handshake.
module uart_rx_peripheral_top #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLK_DIV    = 27,
    parameter int unsigned PAR_EN     = 1,
    parameter int unsigned PAR_TYPE   = 0
) (
    input  logic               i_uart_clk,
    input  logic               i_uart_rst_n,
    uart_rx_peripheral_top_if.slave bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic            prev;
    logic            rx_s;
    logic [PW-1:0]   presc;
    logic [3:0]      scnt;
    logic            smp7;
    logic            smp8;
    logic [2:0]      idx;
    logic [7:0]      data;
    logic            par_bit;
    logic            par_err_q;
    logic            stop_err_q;
    logic            overrun_q;

    logic            tick;
    logic            decide;
    logic            bit_end;
    logic            majority;
    logic            start_det;
    logic            par_ok;
    logic            push;
    logic            pop;
    logic            full;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign rx_s = sync2;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.i_uart_rx_sdata;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        tick      = (presc == PW'(CLK_DIV - 1));
        decide    = tick && (scnt == 4'd9);
        bit_end   = tick && (scnt == 4'd15);
        majority  = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
        start_det = (state == IDLE) && prev && !rx_s;
        full      = (count == CW'(FIFO_DEPTH));
        pop       = (count != '0) && bus.i_uart_rx_ready;
        par_ok    = 1'b1;
        if (PAR_EN != 0) begin
            par_ok = (PAR_TYPE != 0) ? (par_bit == ~^data) : (par_bit == ^data);
        end
        // A slot freed by a pop on the same clock lets a frame in even when full.
        push = (state == STOP) && decide && majority && par_ok && (!full || pop);
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            scnt       <= '0;
            smp7       <= 1'b0;
            smp8       <= 1'b0;
            idx        <= '0;
            data       <= '0;
            par_bit    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (start_det || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (start_det) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= scnt + 4'd1;
            end

            if (tick && scnt == 4'd7) begin
                smp7 <= rx_s;
            end
            if (tick && scnt == 4'd8) begin
                smp8 <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                    end
                end
                START: begin
                    if (decide && majority) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (decide) begin
                        data[idx] <= majority;
                    end
                    if (bit_end) begin
                        if (idx == 3'd7) begin
                            if (PAR_EN != 0) begin
                                state <= PARITY;
                            end else begin
                                state <= STOP;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        par_bit <= majority;
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (decide) begin
                        state <= IDLE;
                        if (!majority) begin
                            stop_err_q <= 1'b1;
                        end else if (!par_ok) begin
                            par_err_q <= 1'b1;
                        end else if (full && !pop) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_uart_clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.o_uart_rx_pdata  = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.o_uart_rx_valid  = (count != '0);
    assign bus.o_uart_fifo_full = full;
    assign bus.o_uart_par_err   = par_err_q;
    assign bus.o_uart_stop_err  = stop_err_q;
    assign bus.o_uart_overrun   = overrun_q;

endmodule
